gate_response_misr: RTL and testbench
=====================================

Name: gate_response_misr

Overview:
- Downstream response compactor for the 10-output combinational gate models (e.g. GateModel outputs N489..N513).
- Each cycle it accepts one 10-bit response vector via valid/ready and folds it into a Galois multiple-input signature register (MISR).
- After a programmed number of vectors it compares the signature against a golden value and reports pass/fail.
- Used by the lab simulator's self-test harness as the sink of the gate-under-test.

Parameters:
- WIDTH, 10, response and signature width.
- POLY, 10'h009, feedback mask, lower coefficients of x^10+x^3+1 (bit i = coefficient of x^i).
- SEED, 10'h000, signature value loaded on start.
- CNT_W, 16, width of the pattern counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
- abort  in  1  returns to IDLE from any state next cycle; signature is kept.
- num_patterns  in  CNT_W  number of vectors to compact; sampled on accepted start.
- golden  in  WIDTH  expected signature; sampled on accepted start.
- resp_valid  in  1  response vector valid.
- resp_data  in  WIDTH  response vector; bit 0 = first output of the gate model's output list.
- resp_ready  out  1  block accepts a vector this cycle.
- busy  out  1  high in RUN or CHECK.
- done  out  1  high while in DONE.
- pass  out  1  compare result; valid while done=1.
- signature  out  WIDTH  current MISR state.
- count  out  CNT_W  vectors accepted in the current run.

Behaviour:
- Reset (async, rst=1): state=IDLE, signature=SEED, count=0, resp_ready=0, busy=0, done=0, pass=0. Stored golden/num_patterns cleared to 0.
- FSM states: IDLE, RUN, CHECK, DONE.
- IDLE/DONE + start:
  - Load signature=SEED, count=0, latch num_patterns and golden, clear pass.
  - Next state is RUN, or CHECK if num_patterns==0.
- RUN:
  - resp_ready=1 combinationally (registered state only, no dependency on resp_valid).
  - A vector is accepted when resp_valid&resp_ready at the clock edge.
  - Compaction: fb=signature[WIDTH-1]; next = {signature[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0) ^ resp_data.
  - count increments on each accepted vector.
  - When the accepted vector makes count == num_patterns, the next state is CHECK. The final vector is compacted in that same edge.
  - No acceptance without resp_valid; stall cycles leave signature and count unchanged.
- CHECK: resp_ready=0; one cycle; pass <= (signature == golden); next state DONE. Latency from the last accept to done=1 is 2 cycles.
- DONE:
  - done=1; pass, signature and count are held.
  - start restarts the run; start and abort in the same cycle: abort wins (go to IDLE).
- start while in RUN or CHECK is ignored.
- abort in RUN: a vector offered that cycle is still accepted and compacted, then the state goes to IDLE.
- count saturates never: num_patterns bounds it. Full range is 1..2^CNT_W-1; 0 means an empty run.
- Reset asserted mid-run discards the run immediately; no partial done.

Decomposition:
- Shared package gate_bist_pkg:
  - state enum (IDLE, RUN, CHECK, DONE);
  - default POLY/SEED constants per gate-model output width;
  - a localparam for the GateModel output width (10).
- One natural sub-module: misr_step, a pure combinational next-signature function (state, data, POLY) -> next. It is reused by the upstream LFSR pattern generator's model.
- The FSM, counter and compare live in the top.

Test Plan:
- Reset then idle: rst pulse -> signature=0x000, count=0, resp_ready=0, done=0, pass=0.
- One vector: start with num_patterns=1, golden=0x001; send resp_data=0x001 -> signature=0x001, count=1, done=1 two cycles after the accept, pass=1.
- Feedback path: num_patterns=2, golden=0x009; send 0x200 then 0x000 -> intermediate signature 0x200, final 0x009, pass=1. Repeat with golden=0x008 -> pass=0.
- Stalls: num_patterns=3, resp_valid toggling 1,0,0,1,0,1 -> exactly 3 accepts, count steps 1,2,3, signature unchanged on stall cycles.
- Empty run and restart: num_patterns=0, golden=SEED -> CHECK then DONE with pass=1, no resp_ready pulse. Start again from DONE -> new run begins, count=0.
- Abort and async reset: abort after 2 of 5 vectors -> IDLE, count=2, done=0. Assert rst mid-run off-edge -> outputs at reset values immediately; start ignored while in RUN.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// rtl/gate_bist_pkg.sv - shared types and constants for the gate-model BIST sink
package gate_bist_pkg;

    localparam int GATE_OUT_W = 10;

    // x^10 + x^3 + 1, lower coefficients only
    localparam logic [GATE_OUT_W-1:0] GATE_POLY_10 = 10'h009;
    localparam logic [GATE_OUT_W-1:0] GATE_SEED_10 = 10'h000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

endpackage

// File: rtl/misr_step.sv
// rtl/misr_step.sv - one Galois MISR compaction step (shift, feedback, fold in data)
module misr_step #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] sig_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] poly_i,
    output logic [WIDTH-1:0] next_o
);

    assign next_o = {sig_i[WIDTH-2:0], 1'b0}
                  ^ (sig_i[WIDTH-1] ? poly_i : '0)
                  ^ data_i;

endmodule

// File: rtl/gate_response_misr.sv
// rtl/gate_response_misr.sv - response compactor: MISR over N vectors, then golden compare
module gate_response_misr
    import gate_bist_pkg::*;
#(
    parameter int                WIDTH = GATE_OUT_W,
    parameter logic [WIDTH-1:0]  POLY  = GATE_POLY_10,
    parameter logic [WIDTH-1:0]  SEED  = GATE_SEED_10,
    parameter int                CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [WIDTH-1:0] golden,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] count
);

    bist_state_e      state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] npat_q, npat_d;
    logic [WIDTH-1:0] golden_q, golden_d;
    logic             pass_q, pass_d;

    logic [WIDTH-1:0] sig_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;

    misr_step #(.WIDTH(WIDTH)) u_misr_step (
        .sig_i  (sig_q),
        .data_i (resp_data),
        .poly_i (POLY),
        .next_o (sig_next)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign accept  = (state_q == ST_RUN) && resp_valid;

    always_comb begin
        state_d  = state_q;
        sig_d    = sig_q;
        cnt_d    = cnt_q;
        npat_d   = npat_q;
        golden_d = golden_q;
        pass_d   = pass_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && !abort) begin
                    sig_d    = SEED;
                    cnt_d    = '0;
                    npat_d   = num_patterns;
                    golden_d = golden;
                    pass_d   = 1'b0;
                    state_d  = (num_patterns == '0) ? ST_CHECK : ST_RUN;
                end
            end
            ST_RUN: begin
                // The final vector is folded in on the same edge that leaves RUN
                if (accept) begin
                    sig_d = sig_next;
                    cnt_d = cnt_inc;
                    if (cnt_inc == npat_q) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                pass_d  = (sig_q == golden_q);
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sig_q    <= SEED;
            cnt_q    <= '0;
            npat_q   <= '0;
            golden_q <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sig_q    <= sig_d;
            cnt_q    <= cnt_d;
            npat_q   <= npat_d;
            golden_q <= golden_d;
            pass_q   <= pass_d;
        end
    end

    assign resp_ready = (state_q == ST_RUN);
    assign busy       = (state_q == ST_RUN) || (state_q == ST_CHECK);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;
    assign signature  = sig_q;
    assign count      = cnt_q;

endmodule

// File: tb/tb_gate_response_misr.sv
// tb/tb_gate_response_misr.sv - scoreboard bench for gate_response_misr
module tb_gate_response_misr;

    localparam int W  = 10;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] num_patterns = '0;
    logic [W-1:0]  golden = '0;
    logic          resp_valid = 1'b0;
    logic [W-1:0]  resp_data = '0;
    logic          resp_ready, busy, done, pass;
    logic [W-1:0]  signature;
    logic [CW-1:0] count;

    gate_response_misr dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .num_patterns (num_patterns),
        .golden       (golden),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_ready   (resp_ready),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature),
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  sig;
        logic [CW-1:0] cnt;
    } acc_exp_t;

    typedef struct packed {
        logic [W-1:0]  sig;
        logic          pass;
        logic [CW-1:0] cnt;
        logic [7:0]    lat;
    } done_exp_t;

    acc_exp_t  acc_q[$];
    done_exp_t done_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int ready_cnt = 0;
    bit pending = 1'b0;
    bit prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares after each accept and on each rising done
    initial begin
        acc_exp_t  e;
        done_exp_t d;
        forever begin
            @(negedge clk);
            cyc++;
            if (resp_ready) ready_cnt++;
            if (rst) begin
                pending   = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (pending) begin
                    if (acc_q.size() == 0) begin
                        check("acc_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = acc_q.pop_front();
                        check("acc_sig", 32'(signature), 32'(e.sig));
                        check("acc_count", 32'(count), 32'(e.cnt));
                    end
                end
                pending = resp_valid && resp_ready;
                if (pending) last_acc = cyc;
                if (done && !prev_done) begin
                    if (done_q.size() == 0) begin
                        check("done_unexpected", 32'd1, 32'd0);
                    end else begin
                        d = done_q.pop_front();
                        check("done_sig", 32'(signature), 32'(d.sig));
                        check("done_pass", 32'(pass), 32'(d.pass));
                        check("done_count", 32'(count), 32'(d.cnt));
                        if (d.lat != 0) check("done_latency", 32'(cyc - last_acc), 32'(d.lat));
                    end
                end
                prev_done = done;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [CW-1:0] np, input logic [W-1:0] g,
                             input logic [W-1:0] esig, input logic epass,
                             input logic [CW-1:0] ecnt, input logic [7:0] lat, input bit push);
        num_patterns = np;
        golden       = g;
        start        = 1'b1;
        tick();
        start = 1'b0;
        if (push) done_q.push_back('{sig: esig, pass: epass, cnt: ecnt, lat: lat});
    endtask

    task automatic send(input logic [W-1:0] data, input logic [W-1:0] esig, input logic [CW-1:0] ecnt);
        resp_data  = data;
        resp_valid = 1'b1;
        acc_q.push_back('{sig: esig, cnt: ecnt});
        tick();
        resp_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (!done && k < limit) begin
            tick();
            k++;
        end
        check("wait_done", 32'(done), 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("reset_sig", 32'(signature), 32'h000);
        check("reset_count", 32'(count), 32'd0);
        check("reset_ready", 32'(resp_ready), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_pass", 32'(pass), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // single vector
        start_run(16'd1, 10'h001, 10'h001, 1'b1, 16'd1, 8'd2, 1'b1);
        send(10'h001, 10'h001, 16'd1);
        wait_done(10);

        // feedback path, matching and mismatching golden
        start_run(16'd2, 10'h009, 10'h009, 1'b1, 16'd2, 8'd2, 1'b1);
        send(10'h200, 10'h200, 16'd1);
        send(10'h000, 10'h009, 16'd2);
        wait_done(10);
        start_run(16'd2, 10'h008, 10'h009, 1'b0, 16'd2, 8'd2, 1'b1);
        send(10'h200, 10'h200, 16'd1);
        send(10'h000, 10'h009, 16'd2);
        wait_done(10);

        // stalls: valid pattern 1,0,0,1,0,1
        start_run(16'd3, 10'h3F6, 10'h3F6, 1'b1, 16'd3, 8'd2, 1'b1);
        send(10'h155, 10'h155, 16'd1);
        resp_data = 10'h3FF;
        tick();
        tick();
        check("stall_sig", 32'(signature), 32'h155);
        check("stall_count", 32'(count), 32'd1);
        send(10'h0AA, 10'h200, 16'd2);
        resp_data = 10'h2AB;
        tick();
        check("stall_sig2", 32'(signature), 32'h200);
        check("stall_count2", 32'(count), 32'd2);
        send(10'h3FF, 10'h3F6, 16'd3);
        wait_done(10);

        // empty run, then restart from DONE
        rc = ready_cnt;
        start_run(16'd0, 10'h000, 10'h000, 1'b1, 16'd0, 8'd0, 1'b1);
        check("empty_busy", 32'(busy), 32'd1);
        check("empty_ready", 32'(resp_ready), 32'd0);
        wait_done(10);
        check("empty_no_ready", 32'(ready_cnt - rc), 32'd0);
        start_run(16'd1, 10'h001, 10'h001, 1'b1, 16'd1, 8'd2, 1'b1);
        check("restart_count", 32'(count), 32'd0);
        check("restart_ready", 32'(resp_ready), 32'd1);
        check("restart_done", 32'(done), 32'd0);
        send(10'h001, 10'h001, 16'd1);
        wait_done(10);

        // start and abort together in DONE: abort wins
        num_patterns = 16'd3;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_win_done", 32'(done), 32'd0);
        check("abort_win_busy", 32'(busy), 32'd0);
        check("abort_win_sig", 32'(signature), 32'h001);

        // abort after 2 of 5
        start_run(16'd5, 10'h000, 10'h000, 1'b0, 16'd0, 8'd0, 1'b0);
        send(10'h001, 10'h001, 16'd1);
        send(10'h003, 10'h001, 16'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_count", 32'(count), 32'd2);
        check("abort_sig", 32'(signature), 32'h001);

        // start ignored in RUN, then async reset mid-run
        start_run(16'd4, 10'h3FF, 10'h000, 1'b0, 16'd0, 8'd0, 1'b0);
        send(10'h123, 10'h123, 16'd1);
        num_patterns = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_start_busy", 32'(busy), 32'd1);
        check("run_start_count", 32'(count), 32'd1);
        check("run_start_ready", 32'(resp_ready), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_sig", 32'(signature), 32'h000);
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_ready", 32'(resp_ready), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();

        check("acc_q_empty", 32'(acc_q.size()), 32'd0);
        check("done_q_empty", 32'(done_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
